// File: rtl/vga_sync_gen_p_if.sv
// Frame-buffer read port and VGA output bundle for vga_sync_gen_p.
// test_en exists only when VGAC_TESTPAT_EN is defined.
interface vga_sync_gen_p_if #(
   parameter int CW    = 4,
   parameter int COL_W = 10,
   parameter int ROW_W = 9
);
   logic [3*CW-1:0]  d_in;
   logic [ROW_W-1:0] row_addr;
   logic [COL_W-1:0] col_addr;
   logic             rdn;
   logic [CW-1:0]    r;
   logic [CW-1:0]    g;
   logic [CW-1:0]    b;
   logic             hs;
   logic             vs;
   logic             frame_start;
`ifdef VGAC_TESTPAT_EN
   logic             test_en;
`endif

   modport master (
      input  d_in,
`ifdef VGAC_TESTPAT_EN
      input  test_en,
`endif
      output row_addr, col_addr, rdn, r, g, b, hs, vs, frame_start
   );

   modport slave (
      output d_in,
`ifdef VGAC_TESTPAT_EN
      output test_en,
`endif
      input  row_addr, col_addr, rdn, r, g, b, hs, vs, frame_start
   );
endinterface

// File: rtl/vga_sync_gen_p.sv
// Parametrised VGA timing generator with a PIPE-cycle frame-buffer read pipeline.
// Defining VGAC_TESTPAT_EN adds test_en and an 8-bar colour test pattern.
module vga_sync_gen_p #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CW       = 4,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int PIPE     = 1,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic             vga_clk,
   input  logic             clrn,
   vga_sync_gen_p_if.master bus
);
   localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HC_W  = $clog2(H_TOT + 1);
   localparam int VC_W  = $clog2(V_TOT + 1);
   localparam int RGB_W = 3 * CW;

   localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOT - 1);
   localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
   localparam logic [HC_W-1:0] H_START    = HC_W'(H_SYNC + H_BP);
   localparam logic [HC_W-1:0] H_END      = HC_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOT - 1);
   localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
   localparam logic [VC_W-1:0] V_START    = VC_W'(V_SYNC + V_BP);
   localparam logic [VC_W-1:0] V_END      = VC_W'(V_SYNC + V_BP + V_ACTIVE);

   logic [HC_W-1:0]  r_h_cnt;
   logic [VC_W-1:0]  r_v_cnt;
   logic             w_act;
   logic             w_hs;
   logic             w_vs;
   logic             w_first;
   logic [COL_W-1:0] w_col;
   logic [ROW_W-1:0] w_row;
   logic [RGB_W-1:0] w_pix;
   logic [RGB_W-1:0] w_rgb;

   logic             r_rdn;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_act_d   [0:PIPE-1];
   logic             r_hs_d    [0:PIPE];
   logic             r_vs_d    [0:PIPE];
   logic             r_first_d [0:PIPE];
   logic [RGB_W-1:0] r_rgb;

   // Raster counters: h wraps every line, v advances only on the h wrap.
   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_h_cnt <= {HC_W{1'b0}};
         r_v_cnt <= {VC_W{1'b0}};
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= {HC_W{1'b0}};
         r_v_cnt <= (r_v_cnt == V_LAST) ? {VC_W{1'b0}} : r_v_cnt + VC_W'(1);
      end else begin
         r_h_cnt <= r_h_cnt + HC_W'(1);
         r_v_cnt <= r_v_cnt;
      end
   end

   always_comb begin
      w_act   = (r_h_cnt >= H_START) && (r_h_cnt < H_END) &&
                (r_v_cnt >= V_START) && (r_v_cnt < V_END);
      w_hs    = (r_h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
      w_vs    = (r_v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
      w_first = w_act && (r_h_cnt == H_START) && (r_v_cnt == V_START);
      w_col   = COL_W'(r_h_cnt - H_START);
      w_row   = ROW_W'(r_v_cnt - V_START);
   end

`ifdef VGAC_TESTPAT_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic       r_tp_line;
   logic       r_tp_d  [0:PIPE-1];
   logic [2:0] r_bar_d [0:PIPE-1];
   logic [2:0] w_bar;

   function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
      return {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
   endfunction

   always_comb begin
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         w_bar = w_bar + ((w_col >= COL_W'(k * BAR_W)) ? 3'd1 : 3'd0);
      end
   end

   // test_en is sampled once per line so the pattern never switches mid-line.
   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_tp_line <= 1'b0;
         for (int i = 0; i < PIPE; i++) begin
            r_tp_d[i]  <= 1'b0;
            r_bar_d[i] <= 3'd0;
         end
      end else begin
         r_tp_line  <= (r_h_cnt == H_LAST) ? bus.test_en : r_tp_line;
         r_tp_d[0]  <= r_tp_line;
         r_bar_d[0] <= w_bar;
         for (int i = 1; i < PIPE; i++) begin
            r_tp_d[i]  <= r_tp_d[i-1];
            r_bar_d[i] <= r_bar_d[i-1];
         end
      end
   end

   always_comb begin
      w_pix = r_tp_d[PIPE-1] ? bar_rgb(r_bar_d[PIPE-1]) : bus.d_in;
   end
`else
   always_comb begin
      w_pix = bus.d_in;
   end
`endif

   always_comb begin
      w_rgb = r_act_d[PIPE-1] ? w_pix : {RGB_W{1'b0}};
   end

   // Stage A addresses, then a PIPE-deep delay so sync/flags meet d_in on its capture edge.
   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_rdn <= 1'b1;
         r_col <= {COL_W{1'b0}};
         r_row <= {ROW_W{1'b0}};
         r_rgb <= {RGB_W{1'b0}};
         for (int i = 0; i < PIPE; i++) begin
            r_act_d[i] <= 1'b0;
         end
         for (int i = 0; i <= PIPE; i++) begin
            r_hs_d[i]    <= ~HS_POL;
            r_vs_d[i]    <= ~VS_POL;
            r_first_d[i] <= 1'b0;
         end
      end else begin
         r_rdn        <= ~w_act;
         r_col        <= w_act ? w_col : {COL_W{1'b0}};
         r_row        <= w_act ? w_row : {ROW_W{1'b0}};
         r_rgb        <= w_rgb;
         r_act_d[0]   <= w_act;
         r_hs_d[0]    <= w_hs;
         r_vs_d[0]    <= w_vs;
         r_first_d[0] <= w_first;
         for (int i = 1; i < PIPE; i++) begin
            r_act_d[i] <= r_act_d[i-1];
         end
         for (int i = 1; i <= PIPE; i++) begin
            r_hs_d[i]    <= r_hs_d[i-1];
            r_vs_d[i]    <= r_vs_d[i-1];
            r_first_d[i] <= r_first_d[i-1];
         end
      end
   end

   assign bus.rdn         = r_rdn;
   assign bus.col_addr    = r_col;
   assign bus.row_addr    = r_row;
   assign bus.r           = r_rgb[3*CW-1:2*CW];
   assign bus.g           = r_rgb[2*CW-1:CW];
   assign bus.b           = r_rgb[CW-1:0];
   assign bus.hs          = r_hs_d[PIPE];
   assign bus.vs          = r_vs_d[PIPE];
   assign bus.frame_start = r_first_d[PIPE];
endmodule

// File: tb/tb_vga_sync_gen_p.sv
// Self-checking bench for vga_sync_gen_p on a reduced raster (23x11) with PIPE=3.
// Outputs are compared every cycle against a pixel-index model of the raster.
module tb_vga_sync_gen_p;
   localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_ACTIVE = 6,  V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int CW = 4, COL_W = 4, ROW_W = 3, PIPE = 3;
   localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
   localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int FRAME = HT * VT;
   localparam int HS0 = H_SYNC + H_BP;
   localparam int VS0 = V_SYNC + V_BP;

   logic vga_clk = 1'b0;
   logic clrn = 1'b0;
   logic [3*CW-1:0] d_in = 12'hABC;
   logic te = 1'b0;

   vga_sync_gen_p_if #(.CW(CW), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();
   assign bus.d_in = d_in;
`ifdef VGAC_TESTPAT_EN
   assign bus.test_en = te;
`endif

   vga_sync_gen_p #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .CW(CW), .COL_W(COL_W), .ROW_W(ROW_W), .PIPE(PIPE),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .vga_clk(vga_clk),
      .clrn(clrn),
      .bus(bus)
   );

   always #5 vga_clk = ~vga_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n = 0;
   int epoch = 0;
   int fs_cnt = 0, rdn_low_cnt = 0, hs_on_cnt = 0, vs_on_cnt = 0;
   logic             hist_rdn [0:7];
   logic [ROW_W-1:0] hist_row [0:7];
   logic [COL_W-1:0] hist_col [0:7];
   bit               te_log   [0:2047];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (epoch %0d, cycle %0d)", name, got, want, epoch, n);
      end
   endtask

   // Pixel p counts raster positions from reset release, row-major.
   function automatic int m_h(input int p);
      return p % HT;
   endfunction
   function automatic int m_v(input int p);
      return (p / HT) % VT;
   endfunction
   function automatic bit m_act(input int p);
      return (m_h(p) >= HS0) && (m_h(p) < HS0 + H_ACTIVE) &&
             (m_v(p) >= VS0) && (m_v(p) < VS0 + V_ACTIVE);
   endfunction
   function automatic logic [11:0] ram_word(input logic [2:0] row, input logic [3:0] col);
      return {col, 1'b0, row, 4'h5};
   endfunction
   function automatic logic [11:0] m_rgb(input int q);
      int s;
      logic [2:0] bi;
      if (!m_act(q)) return 12'h000;
      s = q - m_h(q);
      if (s != 0 && te_log[s]) begin
         bi = 3'((m_h(q) - HS0) / (H_ACTIVE / 8));
         return {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
      end
      return ram_word(3'(m_v(q) - VS0), 4'(m_h(q) - HS0));
   endfunction

   task automatic compare_outputs();
      int a, q;
      logic e_rdn, e_hs, e_vs, e_fs;
      logic [COL_W-1:0] e_col;
      logic [ROW_W-1:0] e_row;
      logic [11:0] e_rgb, got_rgb;
      a = n - 1;
      q = n - 1 - PIPE;
      if (a >= 0 && m_act(a)) begin
         e_rdn = 1'b0; e_col = 4'(m_h(a) - HS0); e_row = 3'(m_v(a) - VS0);
      end else begin
         e_rdn = 1'b1; e_col = 4'd0; e_row = 3'd0;
      end
      if (q >= 0) begin
         e_hs  = (m_h(q) < H_SYNC) ? HS_POL : ~HS_POL;
         e_vs  = (m_v(q) < V_SYNC) ? VS_POL : ~VS_POL;
         e_fs  = m_act(q) && m_h(q) == HS0 && m_v(q) == VS0;
         e_rgb = m_rgb(q);
      end else begin
         e_hs = ~HS_POL; e_vs = ~VS_POL; e_fs = 1'b0; e_rgb = 12'h000;
      end
      got_rgb = {bus.r, bus.g, bus.b};
      check("rdn", 32'(bus.rdn), 32'(e_rdn));
      check("col_addr", 32'(bus.col_addr), 32'(e_col));
      check("row_addr", 32'(bus.row_addr), 32'(e_row));
      check("hs", 32'(bus.hs), 32'(e_hs));
      check("vs", 32'(bus.vs), 32'(e_vs));
      check("frame_start", 32'(bus.frame_start), 32'(e_fs));
      check("rgb", 32'(got_rgb), 32'(e_rgb));
      // hand-computed anchors for the model
      if (n == PIPE)     check("hs_before_edge", 32'(bus.hs), 32'(1'b1));
      if (n == PIPE + 1) check("hs_assert_edge", 32'(bus.hs), 32'(1'b0));
      if (n == PIPE + 1) check("vs_assert_edge", 32'(bus.vs), 32'(1'b1));
      if (epoch == 1) begin
         if (n == 98)  check("first_addr", 32'({bus.rdn, bus.row_addr, bus.col_addr}), 32'h000);
         if (n == 113) check("last_col", 32'({bus.rdn, bus.col_addr}), 32'h0F);
         if (n == 213) check("last_row", 32'({bus.rdn, bus.row_addr}), 32'h5);
         if (n == 101) check("fs_pixel", 32'({bus.frame_start, got_rgb}), 32'h1005);
         if (n == 102) check("second_pixel", 32'({bus.frame_start, got_rgb}), 32'h0105);
         if (n >= 1 && n <= 2 * FRAME && !bus.rdn) rdn_low_cnt++;
         if (n >= PIPE + 1 && n <= PIPE + 2 * FRAME) begin
            if (bus.frame_start) fs_cnt++;
            if (bus.hs == HS_POL) hs_on_cnt++;
            if (bus.vs == VS_POL) vs_on_cnt++;
         end
      end
`ifdef VGAC_TESTPAT_EN
      if (epoch == 2) begin
         if (n == 103) check("bar1", 32'(got_rgb), 32'h00F);
         if (n == 109) check("bar4", 32'(got_rgb), 32'hF00);
         if (n == 116) check("bar7", 32'(got_rgb), 32'hFFF);
      end
`endif
   endtask

   task automatic run_cycles(input int k);
      int j;
      for (int i = 0; i < k; i++) begin
         te_log[n + 1] = te;
         @(posedge vga_clk);
         n = n + 1;
         #1;
         hist_rdn[n % 8] = bus.rdn;
         hist_row[n % 8] = bus.row_addr;
         hist_col[n % 8] = bus.col_addr;
         j = n - (PIPE - 1);
         if (j >= 0 && !hist_rdn[j % 8]) d_in = ram_word(hist_row[j % 8], hist_col[j % 8]);
         else d_in = 12'hABC;
         @(negedge vga_clk);
         compare_outputs();
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rdn"}, 32'(bus.rdn), 32'(1'b1));
      check({tag, "_addr"}, 32'({bus.row_addr, bus.col_addr}), 32'h000);
      check({tag, "_rgb"}, 32'({bus.r, bus.g, bus.b}), 32'h000);
      check({tag, "_hs"}, 32'(bus.hs), 32'(1'b1));
      check({tag, "_vs"}, 32'(bus.vs), 32'(1'b0));
      check({tag, "_fs"}, 32'(bus.frame_start), 32'(1'b0));
   endtask

   task automatic new_epoch();
      n = 0;
      epoch = epoch + 1;
      for (int i = 0; i < 8; i++) begin
         hist_rdn[i] = 1'b1; hist_row[i] = 3'd0; hist_col[i] = 4'd0;
      end
      for (int i = 0; i < 2048; i++) te_log[i] = 1'b0;
      d_in = 12'hABC;
   endtask

   initial begin
      #100;
      check_reset("por");
      #2;
      new_epoch();
      clrn = 1'b1;
      run_cycles(2 * FRAME + PIPE + 5);
      check("fs_per_2frames", 32'(fs_cnt), 32'd2);
      check("rdn_low_2frames", 32'(rdn_low_cnt), 32'd192);
      check("hs_on_2frames", 32'(hs_on_cnt), 32'd66);
      check("vs_on_2frames", 32'(vs_on_cnt), 32'd92);
      // stop with counters at v=4, h=10 (mid active area, pipeline full of colour)
      run_cycles(2 * FRAME + 102 - n);
      @(posedge vga_clk);
      #2;
      clrn = 1'b0;
      #1;
      check_reset("async");
      @(posedge vga_clk);
      @(negedge vga_clk);
      #2;
      new_epoch();
      clrn = 1'b1;
      run_cycles(40);
`ifdef VGAC_TESTPAT_EN
      te = 1'b1;
`endif
      run_cycles(FRAME);
      te = 1'b0;
      run_cycles(30);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
